// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and types for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : Pipeline register with load / hold / flush; flush writes a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int unsigned PC_W       = 64,
    parameter int unsigned INST_W     = 32,
    parameter logic [31:0] FLUSH_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;

    // Flush outranks load so a redirect can never let a stale word through.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            pc_q    <= '0;
            inst_q  <= INST_W'(FLUSH_INST);
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC owner and IF/ID capture with stall, redirect and fault halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] MEM_BYTES = 64'd16,
    parameter logic [31:0] NOP_INST  = riscv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] inst_addr,
    input  logic [31:0] inst_in,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        halted,
    output logic [1:0]  fault_code
);

    localparam logic [63:0] C_LAST_PC = MEM_BYTES - 64'd4;

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic [1:0]   fault_q, fault_d;
    logic         load, flush;
    logic         out_of_range;

    // A memory smaller than one word has no legal fetch address at all.
    assign out_of_range = (MEM_BYTES < 64'd4) || (pc_q > C_LAST_PC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    if (branch_target[1:0] == 2'b00) begin
                        pc_d = branch_target;
                    end else begin
                        fault_d = FAULT_MISALIGN;
                        state_d = S_HALT;
                    end
                end else if (stall) begin
                    // everything holds
                end else if (out_of_range) begin
                    flush   = 1'b1;
                    fault_d = FAULT_RANGE;
                    state_d = S_HALT;
                end else begin
                    load    = 1'b1;
                    pc_d    = pc_q + 64'd4;
                    count_d = count_q + 32'd1;
                end
            end
            S_HALT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = S_HALT;
                flush   = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .PC_W       (64),
        .INST_W     (32),
        .FLUSH_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .flush_i (flush),
        .pc_i    (pc_q),
        .inst_i  (inst_in),
        .pc_o    (if_id_pc),
        .inst_o  (if_id_inst),
        .valid_o (if_id_valid)
    );

    assign inst_addr   = pc_q;
    assign fetch_count = count_q;
    assign halted      = (state_q == S_HALT);
    assign fault_code  = fault_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed vector table plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          MEM = 16;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] inst_addr;
    logic [31:0] inst_in;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic [1:0]  fault_code;

    logic [7:0] mem [MEM];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .MEM_BYTES (64'd16),
        .NOP_INST  (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_addr     (inst_addr),
        .inst_in       (inst_in),
        .if_id_pc      (if_id_pc),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count),
        .halted        (halted),
        .fault_code    (fault_code)
    );

    function automatic logic [31:0] rd_word(input logic [63:0] a);
        if (a <= 64'(MEM - 4))
            return {mem[a[3:0] + 4'd3], mem[a[3:0] + 4'd2], mem[a[3:0] + 4'd1], mem[a[3:0]]};
        return 32'hDEAD_BEEF;
    endfunction

    // Little-endian combinational instruction memory.
    always_comb inst_in = rd_word(inst_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_words(input logic [31:0] w0, w1, w2, w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
                mem[i*4 + b] = w[i][b*8 +: 8];
    endtask

    task automatic drive(input logic r, s, b, input logic [63:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
    endtask

    typedef struct {
        logic        rst, stl, br;
        logic [63:0] tgt;
        logic [63:0] pc, ifpc;
        logic [31:0] inst, cnt;
        logic        v, halt;
        logic [1:0]  fault;
    } vec_t;

    function automatic vec_t mk(input logic r, s, b, input logic [63:0] t,
                                input logic [63:0] pc, ifpc, input logic [31:0] inst,
                                input logic v, input logic [31:0] cnt,
                                input logic [1:0] f, input logic h);
        vec_t x;
        x.rst = r; x.stl = s; x.br = b; x.tgt = t; x.pc = pc; x.ifpc = ifpc;
        x.inst = inst; x.v = v; x.cnt = cnt; x.fault = f; x.halt = h;
        return x;
    endfunction

    task automatic check_all(input string tag, input logic [63:0] pc, ifpc,
                             input logic [31:0] inst, input logic v,
                             input logic [31:0] cnt, input logic [1:0] f, input logic h);
        chk({tag, ".inst_addr"},   inst_addr,   pc);
        chk({tag, ".if_id_pc"},    if_id_pc,    ifpc);
        chk({tag, ".if_id_inst"},  64'(if_id_inst), 64'(inst));
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(v));
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(cnt));
        chk({tag, ".fault_code"},  64'(fault_code),  64'(f));
        chk({tag, ".halted"},      64'(halted),      64'(h));
    endtask

    // Reference model state, advanced by the architectural rules.
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_inst, m_cnt;
    logic        m_v, m_halt;
    logic [1:0]  m_fault;

    task automatic model_step(input logic r, s, b, input logic [63:0] t);
        if (r) begin
            m_pc = 0; m_ifpc = 0; m_inst = NOP; m_v = 0; m_cnt = 0; m_fault = 0; m_halt = 0;
        end else if (m_halt) begin
            m_ifpc = 0; m_inst = NOP; m_v = 0;
        end else if (b) begin
            m_ifpc = 0; m_inst = NOP; m_v = 0;
            if (t % 4 == 0) m_pc = t;
            else begin m_fault = 2'b01; m_halt = 1; end
        end else if (!s) begin
            if (m_pc + 4 > MEM) begin
                m_ifpc = 0; m_inst = NOP; m_v = 0; m_fault = 2'b10; m_halt = 1;
            end else begin
                m_inst = rd_word(m_pc); m_ifpc = m_pc; m_v = 1;
                m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            end
        end
    endtask

    localparam logic [31:0] W0 = 32'h0F05_3483, W1 = 32'h009A_84B3,
                            W2 = 32'h0014_8493, W3 = 32'h0E95_3823;

    vec_t vecs [17];

    initial begin
        vecs[0]  = mk(1,0,0,0,  0, 0, NOP,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,  4, 0, W0, 1,1,0,0);
        vecs[2]  = mk(0,1,0,0,  4, 0, W0, 1,1,0,0);
        vecs[3]  = mk(0,1,0,0,  4, 0, W0, 1,1,0,0);
        vecs[4]  = mk(0,0,0,0,  8, 4, W1, 1,2,0,0);
        vecs[5]  = mk(0,1,1,0,  0, 0, NOP,0,2,0,0);
        vecs[6]  = mk(0,0,0,0,  4, 0, W0, 1,3,0,0);
        vecs[7]  = mk(0,0,0,0,  8, 4, W1, 1,4,0,0);
        vecs[8]  = mk(0,0,0,0, 12, 8, W2, 1,5,0,0);
        vecs[9]  = mk(0,0,0,0, 16,12, W3, 1,6,0,0);
        vecs[10] = mk(0,0,0,0, 16, 0, NOP,0,6,2,1);
        vecs[11] = mk(0,0,1,0, 16, 0, NOP,0,6,2,1);
        vecs[12] = mk(1,0,0,0,  0, 0, NOP,0,0,0,0);
        vecs[13] = mk(0,0,0,0,  4, 0, W0, 1,1,0,0);
        vecs[14] = mk(0,0,1,6,  4, 0, NOP,0,1,1,1);
        vecs[15] = mk(0,0,0,0,  4, 0, NOP,0,1,1,1);
        vecs[16] = mk(1,0,0,0,  0, 0, NOP,0,0,0,0);

        load_words(W0, W1, W2, W3);
        drive(1, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifpc, vecs[i].inst,
                      vecs[i].v, vecs[i].cnt, vecs[i].fault, vecs[i].halt);
        end

        // Reset wins over a simultaneous misaligned branch and stall.
        drive(0, 0, 0, 0); @(posedge clk); #1;
        drive(1, 1, 1, 64'd6); @(posedge clk); #1;
        check_all("rst_over_branch", 0, 0, NOP, 0, 0, 0, 0);
        // Aligned branch to the last legal word, then run off the end.
        drive(0, 0, 1, 64'd12); @(posedge clk); #1;
        check_all("br_last", 12, 0, NOP, 0, 0, 0, 0);
        drive(0, 0, 0, 0); @(posedge clk); #1;
        check_all("fetch_last", 16, 12, W3, 1, 1, 0, 0);
        drive(0, 1, 0, 0); @(posedge clk); #1;
        check_all("stall_at_end", 16, 12, W3, 1, 1, 0, 0);
        drive(0, 0, 0, 0); @(posedge clk); #1;
        check_all("range_fault", 16, 0, NOP, 0, 1, 2, 1);

        // Randomized run against the reference model.
        for (int i = 0; i < MEM; i++) mem[i] = 8'($urandom);
        drive(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            logic r, s, b;
            logic [63:0] t;
            r = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 64'($urandom_range(0, 20));
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            drive(r, s, b, t);
            model_step(r, s, b, t);
            @(posedge clk); #1;
            check_all($sformatf("rnd%0d", n), m_pc, m_ifpc, m_inst, m_v, m_cnt, m_fault, m_halt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed, little-endian instruction memory (64-bit address in, 32-bit instruction out, combinational read).
- Owns the program counter and drives the memory address.
- Captures the returned instruction into the IF/ID pipeline register for the parser/decoder.
- Handles stall, branch redirect/flush, misaligned targets and fetch beyond the memory image.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MEM_BYTES, 16, size of the instruction memory in bytes. Legal fetch requires PC + 3 <= MEM_BYTES - 1.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) written into IF/ID on flush or reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from downstream; hold PC and IF/ID.
- branch_taken  input  1  redirect request from execute stage.
- branch_target  input  64  redirect address; must be 4-byte aligned.
- inst_addr  output  64  address to instruction memory; equals PC register (combinational from register).
- inst_in  input  32  instruction returned by memory for inst_addr, same cycle.
- if_id_pc  output  64  PC of the latched instruction.
- if_id_inst  output  32  latched instruction.
- if_id_valid  output  1  latched instruction is real (not bubble).
- fetch_count  output  32  number of instructions latched valid; wraps modulo 2^32.
- halted  output  1  stage is in HALT state.
- fault_code  output  2  00 none, 01 misaligned branch target, 10 PC beyond MEM_BYTES. Sticky until reset.

Behaviour:
- Reset (sync, active-high, highest priority): PC=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, fetch_count=0, state=RUN, fault_code=00, halted=0.
- Reset mid-operation discards any pending stall, branch or fault on that edge.
- FSM has two states, RUN and HALT. HALT is left only by reset.
- RUN, per-edge priority: branch_taken > stall > out-of-range check > normal fetch.
- branch_taken=1, branch_target[1:0]==0: PC<=branch_target; IF/ID flushed (valid=0, inst=NOP_INST, pc=0). Applies even when stall=1 (branch wins over stall).
- branch_taken=1, branch_target[1:0]!=0: PC holds; IF/ID flushed; fault_code<=01; state<=HALT.
- stall=1, no branch: PC, IF/ID and fetch_count all hold.
- Out of range (PC > MEM_BYTES-4, unsigned 64-bit compare), no branch, no stall: inst_in is not latched; IF/ID flushed; fault_code<=10; state<=HALT.
- Normal fetch: if_id_inst<=inst_in, if_id_pc<=PC, if_id_valid<=1, PC<=PC+4 (64-bit, wraps at 2^64), fetch_count<=fetch_count+1.
- Latency: instruction at address A is visible on if_id_* on the edge after inst_addr=A, i.e. one cycle.
- HALT: halted=1; PC holds; if_id_valid=0 with inst=NOP_INST; inputs ignored; fault_code frozen.
- inst_addr always equals the PC register, including in HALT.

Decomposition:
- Shared package riscv_pkg holds: NOP_INST constant, fault_code encodings (FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE), FSM state enum (S_RUN, S_HALT).
- One natural sub-module: if_id_reg, the pipeline register with load/hold/flush controls, reusable for later pipeline registers.
- PC logic and FSM stay in fetch_stage.

Test Plan:
- Straight-line fetch: memory words 0x0F053483, 0x009A84B3, 0x00148493, 0x0E953823 at 0,4,8,12; release reset. Next four edges latch (pc, inst) = (0,0x0F053483), (4,0x009A84B3), (8,0x00148493), (12,0x0E953823). fetch_count reaches 4.
- Run-off end: continue the above. PC=16 gives fault_code=10, halted=1, if_id_valid=0 and PC stays 16 on all later edges.
- Stall: stall=1 for 2 cycles with PC=4. inst_addr stays 4 and if_id holds (0,0x0F053483). Release: next edge latches (4,0x009A84B3).
- Branch over stall: PC=8, stall=1, branch_taken=1, target=0. Next edge PC=0 and if_id_valid=0 (NOP_INST). Following edge latches (0,0x0F053483).
- Misaligned target: branch_target=6 gives fault_code=01, halted=1 and PC unchanged.
- Reset mid-HALT: assert reset one cycle while halted. Then PC=0, fault_code=00, halted=0, fetch_count=0, and fetch resumes at 0.
